// File: rtl/rtc_bus_pkg.sv
// Shared encodings and defaults for the RTC bus arbiter.
package rtc_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GUARD = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      G_NONE  = 2'd0,
      G_INIT  = 2'd1,
      G_READ  = 2'd2,
      G_WRITE = 2'd3
   } grant_e;

   localparam int DEF_GUARD_CYC   = 2;
   localparam int DEF_TIMEOUT_CYC = 255;
   localparam int DEF_TW          = 8;

endpackage

// File: rtl/rtc_arb_counter.sv
// Loadable up-counter shared by the grant timeout and the guard delay.
// Load clears to zero and has priority over increment; eq is a live compare.
module rtc_arb_counter #(
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic          inc,
   input  logic [TW-1:0] cmp_val,
   output logic          eq
);

   logic [TW-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign eq = (cnt == cmp_val);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Grants the shared RTC bus to one of init/read/write; init first, R/W alternate on ties.
// Grant visible one cycle after the request is sampled in IDLE; guard gap between owners.
module rtc_bus_arbiter
   import rtc_bus_pkg::*;
#(
   parameter int GUARD_CYC   = DEF_GUARD_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int TW          = DEF_TW
) (
   input  logic clk,
   input  logic reset,
   input  logic req_i,
   input  logic req_r,
   input  logic req_w,
   input  logic done_i,
   input  logic done_r,
   input  logic done_w,
   output logic seli,
   output logic selr,
   output logic selw,
   output logic busy,
   output logic init_ok,
   output logic timeout_err
);

   localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT_CYC);
   // Guard compare is against the last guard cycle's count, hence the minus one.
   localparam logic [TW-1:0] GD_VAL = (GUARD_CYC > 0) ? TW'(GUARD_CYC - 1) : '0;

   state_e        state_q, state_d;
   grant_e        gnt_q, gnt_d;
   logic          last_rw_q, last_rw_d;   // 1: write was served last
   logic          init_ok_d;
   logic          to_d;
   logic          cnt_load, cnt_inc, cnt_eq;
   logic [TW-1:0] cmp_val;
   logic          gdone, greq;
   logic          elig_r, elig_w;

   rtc_arb_counter #(.TW(TW)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .load    (cnt_load),
      .inc     (cnt_inc),
      .cmp_val (cmp_val),
      .eq      (cnt_eq)
   );

   always_comb begin
      gdone = 1'b0;
      greq  = 1'b0;
      case (gnt_q)
         G_INIT:  begin gdone = done_i; greq = req_i; end
         G_READ:  begin gdone = done_r; greq = req_r; end
         G_WRITE: begin gdone = done_w; greq = req_w; end
         default: ;
      endcase
   end

   assign elig_r = req_r & init_ok;
   assign elig_w = req_w & init_ok;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_rw_d = last_rw_q;
      init_ok_d = init_ok;
      to_d      = 1'b0;
      cnt_load  = 1'b0;
      cnt_inc   = 1'b0;
      cmp_val   = TO_VAL;
      case (state_q)
         ST_IDLE: begin
            cnt_load = 1'b1;
            if (req_i) begin
               gnt_d   = G_INIT;
               state_d = ST_GRANT;
            end else if (elig_r && (!elig_w || last_rw_q)) begin
               gnt_d     = G_READ;
               last_rw_d = 1'b0;
               state_d   = ST_GRANT;
            end else if (elig_w) begin
               gnt_d     = G_WRITE;
               last_rw_d = 1'b1;
               state_d   = ST_GRANT;
            end
         end
         ST_GRANT: begin
            cnt_inc = 1'b1;
            // Priority: done, then request withdrawal, then timeout.
            if (gdone || !greq || cnt_eq) begin
               gnt_d    = G_NONE;
               cnt_load = 1'b1;
               if (gdone && (gnt_q == G_INIT)) begin
                  init_ok_d = 1'b1;
               end
               to_d    = !gdone && greq;
               state_d = (GUARD_CYC == 0) ? ST_IDLE : ST_GUARD;
            end
         end
         ST_GUARD: begin
            cmp_val = GD_VAL;
            cnt_inc = 1'b1;
            if (cnt_eq) begin
               cnt_load = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = G_NONE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         gnt_q       <= G_NONE;
         last_rw_q   <= 1'b1;
         init_ok     <= 1'b0;
         timeout_err <= 1'b0;
         seli        <= 1'b0;
         selr        <= 1'b0;
         selw        <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         last_rw_q   <= last_rw_d;
         init_ok     <= init_ok_d;
         timeout_err <= to_d;
         seli        <= (gnt_d == G_INIT);
         selr        <= (gnt_d == G_READ);
         selw        <= (gnt_d == G_WRITE);
      end
   end

   assign busy = (state_q != ST_IDLE);

endmodule
